// File: rtl/serial_add_ctrl_if.sv
// serial_add_ctrl_if: operand and result valid/ready handshakes for the bit-serial adder
interface serial_add_ctrl_if #(parameter int WIDTH = 8);
    logic in_valid, in_ready, out_valid, out_ready, cout_out, busy;
    logic [WIDTH-1:0] a_in, b_in, sum_out;
    modport master (
        output in_valid, a_in, b_in, out_ready,
        input  in_ready, out_valid, sum_out, cout_out, busy
    );
    modport slave (
        input  in_valid, a_in, b_in, out_ready,
        output in_ready, out_valid, sum_out, cout_out, busy
    );
endinterface

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: LSB-first bit-serial adder sharing one full-adder slice, one bit per clock
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    serial_add_ctrl_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d, res_q, res_d, sum_nx;
    logic [CW-1:0] cnt_q, cnt_d;
    logic carry_q, carry_d, cout_q, cout_d, s, c, last;
    logic [1:0] h0, h1;

    function automatic logic [1:0] halfadd(input logic x, input logic y);
        return {x & y, x ^ y};
    endfunction

    // full-adder slice built from two half adders plus an OR on the carries
    assign h0 = halfadd(a_q[0], b_q[0]);
    assign h1 = halfadd(h0[0], carry_q);
    assign s = h1[0];
    assign c = h0[1] | h1[1];
    assign last = cnt_q == CW'(WIDTH - 1);

    generate
        if (WIDTH == 1) begin : g_w1
            assign sum_nx = s;
        end else begin : g_wn
            assign sum_nx = {s, sum_q[WIDTH-1:1]};
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        a_d = a_q;
        b_d = b_q;
        sum_d = sum_q;
        res_d = res_q;
        carry_d = carry_q;
        cout_d = cout_q;
        cnt_d = cnt_q;
        case (state_q)
            IDLE: if (bus.in_valid) begin
                a_d = bus.a_in;
                b_d = bus.b_in;
                sum_d = '0;
                carry_d = 1'b0;
                cnt_d = '0;
                state_d = RUN;
            end
            RUN: begin
                a_d = a_q >> 1;
                b_d = b_q >> 1;
                sum_d = sum_nx;
                carry_d = c;
                cnt_d = last ? cnt_q : cnt_q + CW'(1);
                // result registers stay separate so they survive the next operand load
                if (last) begin
                    res_d = sum_nx;
                    cout_d = c;
                    state_d = DONE;
                end
            end
            DONE: if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            a_q <= '0;
            b_q <= '0;
            sum_q <= '0;
            res_q <= '0;
            carry_q <= 1'b0;
            cout_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            state_q <= state_d;
            a_q <= a_d;
            b_q <= b_d;
            sum_q <= sum_d;
            res_q <= res_d;
            carry_q <= carry_d;
            cout_q <= cout_d;
            cnt_q <= cnt_d;
        end
    end

    assign bus.in_ready = state_q == IDLE;
    assign bus.out_valid = state_q == DONE;
    assign bus.busy = state_q != IDLE;
    assign bus.sum_out = res_q;
    assign bus.cout_out = cout_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: directed and random operand pairs against an arithmetic sum model, WIDTH 8 and 1
module tb_serial_add_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int total = 0;
    int passed = 0;
    logic [7:0] ra [0:20];
    logic [7:0] rb [0:20];
    logic seen;

    always #5 clk = ~clk;

    serial_add_ctrl_if #(.WIDTH(8)) b8 ();
    serial_add_ctrl_if #(.WIDTH(1)) b1 ();
    serial_add_ctrl #(.WIDTH(8)) dut8 (.clk_i(clk), .rst_ni(rst_n), .bus(b8.slave));
    serial_add_ctrl #(.WIDTH(1)) dut1 (.clk_i(clk), .rst_ni(rst_n), .bus(b1.slave));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // caller is at a negedge; ends at the negedge after the result retires
    task automatic run8(input logic [7:0] a, input logic [7:0] b, input int hold, input bit poke,
                        input bit chain, input logic [7:0] na, input logic [7:0] nb);
        logic [8:0] exp;
        int lat;
        exp = {1'b0, a} + {1'b0, b};
        chk("accept_ready", 32'(b8.in_ready), 1);
        b8.in_valid = 1'b1;
        b8.a_in = a;
        b8.b_in = b;
        @(negedge clk);
        b8.in_valid = 1'b0;
        chk("run_busy", 32'({b8.busy, b8.in_ready, b8.out_valid}), 32'b100);
        lat = 0;
        while (!b8.out_valid && lat < 20) begin
            if (poke && lat == 2) begin
                b8.in_valid = 1'b1;
                b8.a_in = 8'h11;
            end
            if (poke && lat == 3) begin
                chk("poke_ignored", 32'(b8.in_ready), 0);
                b8.in_valid = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, 8);
        chk("result", 32'({b8.cout_out, b8.sum_out}), 32'(exp));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold", 32'({b8.out_valid, b8.cout_out, b8.sum_out}), 32'({1'b1, exp}));
        end
        b8.out_ready = 1'b1;
        if (chain) begin
            b8.in_valid = 1'b1;
            b8.a_in = na;
            b8.b_in = nb;
        end
        @(negedge clk);
        b8.out_ready = 1'b0;
        chk("retired_idle", 32'({b8.out_valid, b8.in_ready, b8.busy}), 32'b010);
        chk("result_kept", 32'({b8.cout_out, b8.sum_out}), 32'(exp));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        b8.in_valid = 1'b0;
        b8.a_in = '0;
        b8.b_in = '0;
        b8.out_ready = 1'b0;
        b1.in_valid = 1'b0;
        b1.a_in = '0;
        b1.b_in = '0;
        b1.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_state8", 32'({b8.out_valid, b8.in_ready, b8.busy}), 32'b010);
        chk("reset_result8", 32'({b8.cout_out, b8.sum_out}), 0);
        chk("reset_state1", 32'({b1.out_valid, b1.in_ready, b1.busy, b1.cout_out, b1.sum_out}), 32'b01000);
        rst_n = 1'b1;
        @(negedge clk);
        run8(8'h00, 8'h00, 0, 1'b0, 1'b0, 8'h00, 8'h00);
        run8(8'hFF, 8'h01, 0, 1'b0, 1'b0, 8'h00, 8'h00);
        run8(8'hA5, 8'h5A, 3, 1'b0, 1'b0, 8'h00, 8'h00);
        run8(8'h03, 8'h04, 0, 1'b1, 1'b0, 8'h00, 8'h00);
        b8.in_valid = 1'b1;
        b8.a_in = 8'hF0;
        b8.b_in = 8'h10;
        @(negedge clk);
        b8.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_state", 32'({b8.out_valid, b8.in_ready, b8.busy}), 32'b010);
        chk("abort_clear", 32'({b8.cout_out, b8.sum_out}), 0);
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            seen = seen | b8.out_valid;
        end
        chk("abort_no_result", 32'(seen), 0);
        for (int i = 0; i < 4; i++) begin
            b1.a_in = 1'(i >> 1);
            b1.b_in = 1'(i & 1);
            b1.in_valid = 1'b1;
            @(negedge clk);
            b1.in_valid = 1'b0;
            chk("w1_run", 32'(b1.out_valid), 0);
            @(negedge clk);
            chk("w1_done", 32'({b1.out_valid, b1.cout_out, b1.sum_out}),
                32'({1'b1, 2'((i >> 1) + (i & 1))}));
            b1.out_ready = 1'b1;
            @(negedge clk);
            b1.out_ready = 1'b0;
        end
        for (int i = 0; i < 21; i++) begin
            ra[i] = 8'($urandom);
            rb[i] = 8'($urandom);
        end
        for (int i = 0; i < 20; i++)
            run8(ra[i], rb[i], int'($urandom_range(0, 2)), 1'b0, (i % 3 == 0) && (i < 19), ra[i+1], rb[i+1]);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
